// File: rtl/endian_swap_pipe_pkg.sv
// Shared types for the endian swap pipeline: per-beat lane permutation modes.
package endian_pkg;

    typedef enum logic [1:0] {
        M_PASS    = 2'b00,
        M_REV     = 2'b01,
        M_SWAP2   = 2'b10,
        M_PAIRREV = 2'b11
    } swap_mode_t;

endpackage

// File: rtl/endian_swap_pipe_if.sv
// Valid/ready stream pair for the endian swap pipeline: the input beat with its mode, and the output beat.
interface endian_swap_pipe_if
    import endian_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    swap_mode_t        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/endian_swap_pipe_lane_permute.sv
// Combinational lane permutation: out lane i takes in lane p(i), where p depends on the mode.
module lane_permute
    import endian_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  swap_mode_t        mode,
    output logic [DATA_W-1:0] data_out
);
    localparam int N = DATA_W / LANE_W;

    // SWAP2 and PAIRREV work on lane pairs, so a beat has to hold a whole number of pairs.
    if (DATA_W % (2 * LANE_W) != 0) begin : g_bad_width
        $error("lane_permute: DATA_W must be a multiple of 2*LANE_W");
    end

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_lane
        localparam int SRC_REV  = N - 1 - gi;
        localparam int SRC_SWAP = gi ^ 1;
        localparam int SRC_PAIR = 2 * (N / 2 - 1 - gi / 2) + (gi % 2);

        assign data_out[gi*LANE_W +: LANE_W] =
            (mode == M_PASS)  ? data[gi*LANE_W       +: LANE_W] :
            (mode == M_REV)   ? data[SRC_REV*LANE_W  +: LANE_W] :
            (mode == M_SWAP2) ? data[SRC_SWAP*LANE_W +: LANE_W] :
                                data[SRC_PAIR*LANE_W +: LANE_W];
    end
endmodule

// File: rtl/endian_swap_pipe.sv
// Streaming lane-permute stage: output register plus one skid entry, so in_ready comes from a flop.
module endian_swap_pipe
    import endian_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    endian_swap_pipe_if.slave bus,
    output logic [CNT_W-1:0] beat_count
);
    logic [DATA_W-1:0] perm_data;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_full_q, skid_full_d;
    logic              in_ready_q,  in_ready_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              in_fire;
    logic              out_fire;

    lane_permute #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_permute (
        .data     (bus.in_data),
        .mode     (bus.in_mode),
        .data_out (perm_data)
    );

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_full_d = skid_full_q;
        cnt_d       = cnt_q;

        if (out_fire) begin
            cnt_d       = cnt_q + 1'b1;
            out_valid_d = skid_full_q;
            out_data_d  = skid_full_q ? skid_data_q : out_data_q;
            skid_full_d = 1'b0;
        end

        // in_fire implies the skid is empty, so the beat lands in the output
        // register unless that register is holding a stalled beat.
        if (in_fire) begin
            if (!out_valid_q || out_fire) begin
                out_data_d  = perm_data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d = perm_data;
                skid_full_d = 1'b1;
            end
        end

        in_ready_d = !skid_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            skid_data_q <= '0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            skid_data_q <= skid_data_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign beat_count    = cnt_q;
endmodule
